// File: rtl/trace_capture_buffer.sv
// Circular instruction-trace recorder. It records retired (PC, instr) pairs
// while armed. On a trigger it records POST_TRIG more entries, then freezes
// so software can read a window around the trigger. Readback is registered.
module trace_capture_buffer #(
  parameter int TRACE_DEPTH    = 64,
  parameter int TRACE_PTR_BITS = $clog2(TRACE_DEPTH),
  parameter int POST_TRIG      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      retire_valid_i,
  input  logic [31:0]               retire_pc_i,
  input  logic [31:0]               retire_instr_i,
  input  logic                      arm_i,
  input  logic                      stop_i,
  input  logic                      sw_trig_i,
  input  logic                      trig_pc_en_i,
  input  logic [31:0]               trig_pc_i,
  input  logic [TRACE_PTR_BITS-1:0] rd_addr_i,
  output logic                      triggered_o,
  output logic [TRACE_PTR_BITS-1:0] wr_ptr_o,
  output logic                      wrapped_o,
  output logic [TRACE_PTR_BITS-1:0] trig_idx_o,
  output logic [1:0]                state_o,
  output logic [31:0]               rd_pc_o,
  output logic [31:0]               rd_instr_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TRACE_PTR_BITS-1:0] PTR_MAX   = '1;
  localparam logic [TRACE_PTR_BITS-1:0] POST_INIT = TRACE_PTR_BITS'(POST_TRIG);
  localparam logic [TRACE_PTR_BITS-1:0] CNT_ONE   = TRACE_PTR_BITS'(1);

  logic [1:0]                state_q, state_d;
  logic [TRACE_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic                      wrapped_q, wrapped_d;
  logic [TRACE_PTR_BITS-1:0] trig_idx_q, trig_idx_d;
  logic                      triggered_q, triggered_d;
  logic [TRACE_PTR_BITS-1:0] post_cnt_q, post_cnt_d;
  logic [31:0]               rd_pc_q, rd_pc_d;
  logic [31:0]               rd_instr_q, rd_instr_d;

  logic [31:0] mem_pc_q    [TRACE_DEPTH];
  logic [31:0] mem_instr_q [TRACE_DEPTH];

  logic we;
  logic trig;

  assign trig = sw_trig_i |
                (trig_pc_en_i & retire_valid_i & (retire_pc_i == trig_pc_i));

  // Control: stop beats arm beats trigger; writes only in ARMED/POST.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wrapped_d   = wrapped_q;
    trig_idx_d  = trig_idx_q;
    triggered_d = triggered_q;
    post_cnt_d  = post_cnt_q;
    we          = 1'b0;
    if (stop_i) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
    end else if (arm_i) begin
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
      post_cnt_d  = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (retire_valid_i) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == PTR_MAX) wrapped_d = 1'b1;
          end
          if (trig) begin
            // Trigger slot is the one being (or about to be) written.
            trig_idx_d = wr_ptr_q;
            if (POST_TRIG == 0) begin
              state_d     = S_DONE;
              triggered_d = 1'b1;
            end else begin
              state_d    = S_POST;
              post_cnt_d = POST_INIT;
            end
          end
        end
        S_POST: begin
          if (retire_valid_i) begin
            we         = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            post_cnt_d = post_cnt_q - 1'b1;
            if (wr_ptr_q == PTR_MAX) wrapped_d = 1'b1;
            if (post_cnt_q == CNT_ONE) begin
              state_d     = S_DONE;
              triggered_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Readback mux: the array is sampled before this cycle's write lands.
  always_comb begin
    rd_pc_d    = mem_pc_q[rd_addr_i];
    rd_instr_d = mem_instr_q[rd_addr_i];
  end

  // Control and readback registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      trig_idx_q  <= '0;
      triggered_q <= 1'b0;
      post_cnt_q  <= '0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wrapped_q   <= wrapped_d;
      trig_idx_q  <= trig_idx_d;
      triggered_q <= triggered_d;
      post_cnt_q  <= post_cnt_d;
      rd_pc_q     <= rd_pc_d;
      rd_instr_q  <= rd_instr_d;
    end
  end

  // Trace storage: not reset, contents only meaningful once written.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_pc_q[wr_ptr_q]    <= retire_pc_i;
      mem_instr_q[wr_ptr_q] <= retire_instr_i;
    end
  end

  assign triggered_o = triggered_q;
  assign wr_ptr_o    = wr_ptr_q;
  assign wrapped_o   = wrapped_q;
  assign trig_idx_o  = trig_idx_q;
  assign state_o     = state_q;
  assign rd_pc_o     = rd_pc_q;
  assign rd_instr_o  = rd_instr_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer: two instances (POST_TRIG=32 and 0) share
// one stimulus stream; a behavioural model checks both every cycle, and
// directed literal checks pin the key scenarios.
module tb_trace_capture_buffer;
  localparam int D = 64;
  localparam int PB = 6;
  localparam int POSTS [2] = '{32, 0};

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic v = 0, arm = 0, stop = 0, sw = 0, pc_en = 0;
  logic [31:0] pc = '0, ins = '0, tpc = '0;
  logic [PB-1:0] rd_addr = '0;

  logic          trg [2];
  logic [PB-1:0] wp  [2];
  logic          wrp [2];
  logic [PB-1:0] tix [2];
  logic [1:0]    st  [2];
  logic [31:0]   rpc [2];
  logic [31:0]   rin [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trace_capture_buffer #(.TRACE_DEPTH(D), .POST_TRIG(32)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .retire_valid_i(v), .retire_pc_i(pc),
    .retire_instr_i(ins), .arm_i(arm), .stop_i(stop), .sw_trig_i(sw),
    .trig_pc_en_i(pc_en), .trig_pc_i(tpc), .rd_addr_i(rd_addr),
    .triggered_o(trg[0]), .wr_ptr_o(wp[0]), .wrapped_o(wrp[0]),
    .trig_idx_o(tix[0]), .state_o(st[0]), .rd_pc_o(rpc[0]), .rd_instr_o(rin[0]));

  trace_capture_buffer #(.TRACE_DEPTH(D), .POST_TRIG(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .retire_valid_i(v), .retire_pc_i(pc),
    .retire_instr_i(ins), .arm_i(arm), .stop_i(stop), .sw_trig_i(sw),
    .trig_pc_en_i(pc_en), .trig_pc_i(tpc), .rd_addr_i(rd_addr),
    .triggered_o(trg[1]), .wr_ptr_o(wp[1]), .wrapped_o(wrp[1]),
    .trig_idx_o(tix[1]), .state_o(st[1]), .rd_pc_o(rpc[1]), .rd_instr_o(rin[1]));

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 recording, 2 recording a fixed number of tail entries, 3 frozen.
  int          m_mode [2];
  int          m_next [2];
  bit          m_wrap [2];
  int          m_tidx [2];
  int          m_left [2];
  bit          m_done [2];
  logic [31:0] m_pc   [2][D];
  logic [31:0] m_in   [2][D];
  bit          m_has  [2][D];
  logic [31:0] m_rpc  [2];
  logic [31:0] m_rin  [2];
  bit          m_rk   [2];

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_next[i] = 0; m_wrap[i] = 0; m_tidx[i] = 0;
      m_left[i] = 0; m_done[i] = 0;
      m_rpc[i] = '0; m_rin[i] = '0; m_rk[i] = 1;
      for (int j = 0; j < D; j++) m_has[i][j] = 0;
    end
  endtask

  task automatic m_record(input int i);
    m_pc[i][m_next[i]] = pc;
    m_in[i][m_next[i]] = ins;
    m_has[i][m_next[i]] = 1;
    m_next[i] = m_next[i] + 1;
    if (m_next[i] == D) begin
      m_next[i] = 0;
      m_wrap[i] = 1;
    end
  endtask

  task automatic m_step();
    bit hit;
    hit = sw || (pc_en && v && pc == tpc);
    for (int i = 0; i < 2; i++) begin
      m_rk[i] = m_has[i][rd_addr];
      m_rpc[i] = m_pc[i][rd_addr];
      m_rin[i] = m_in[i][rd_addr];
      if (stop) begin
        m_mode[i] = 0; m_done[i] = 0;
      end else if (arm) begin
        m_mode[i] = 1; m_next[i] = 0; m_wrap[i] = 0; m_done[i] = 0;
      end else if (m_mode[i] == 1) begin
        int slot;
        slot = m_next[i];
        if (v) m_record(i);
        if (hit) begin
          m_tidx[i] = slot;
          m_left[i] = POSTS[i];
          if (POSTS[i] == 0) begin m_mode[i] = 3; m_done[i] = 1; end
          else m_mode[i] = 2;
        end
      end else if (m_mode[i] == 2 && v) begin
        m_record(i);
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin m_mode[i] = 3; m_done[i] = 1; end
      end
    end
  endtask

  task automatic cmp(input string name, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[dut%0d] at %0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  always @(negedge rst_ni) m_reset();

  // Step the model on each edge, compare just after the DUT settles.
  always @(posedge clk) begin
    if (!rst_ni) m_reset();
    else m_step();
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp("state", i, st[i], m_mode[i]);
      cmp("wr_ptr", i, wp[i], m_next[i]);
      cmp("wrapped", i, wrp[i], m_wrap[i]);
      cmp("trig_idx", i, tix[i], m_tidx[i]);
      cmp("triggered", i, trg[i], m_done[i]);
      if (m_rk[i]) begin
        cmp("rd_pc", i, rpc[i], m_rpc[i]);
        cmp("rd_instr", i, rin[i], m_rin[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input bit vv, input logic [31:0] p, input logic [31:0] n,
                     input bit a, input bit s, input bit t);
    v = vv; pc = p; ins = n; arm = a; stop = s; sw = t;
    @(negedge clk);
    v = 0; arm = 0; stop = 0; sw = 0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    cmp("rst_state", 0, st[0], 0);
    cmp("rst_wr_ptr", 0, wp[0], 0);
    cmp("rst_rd_pc", 0, rpc[0], 0);
    rst_ni = 1'b1;

    // Retires while idle produce no writes.
    for (int k = 0; k < 10; k++) cyc(1, 32'h100 + 4 * k, k, 0, 0, 0);
    cmp("idle_wr_ptr", 0, wp[0], 0);
    cmp("idle_state", 0, st[0], 0);
    cmp("idle_trig", 0, trg[0], 0);

    // Basic capture and readback.
    cyc(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 32'h100 + 4 * k, 32'hA000 + k, 0, 0, 0);
    cmp("basic_wr_ptr", 0, wp[0], 5);
    cmp("basic_wrapped", 0, wrp[0], 0);
    rd_addr = 3;
    cyc(0, 0, 0, 0, 0, 0);
    cmp("basic_rd_pc", 0, rpc[0], 32'h10C);
    cmp("basic_rd_instr", 0, rin[0], 32'hA003);

    // PC-match trigger at PC 0x200 (retire #128, slot 0 after a wrap).
    pc_en = 1; tpc = 32'h200;
    cyc(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 200; k++) cyc(1, 4 * k, ~k, 0, 0, 0);
    cmp("pct_tidx", 0, tix[0], 0);
    cmp("pct_trig", 0, trg[0], 1);
    cmp("pct_state", 0, st[0], 3);
    cmp("pct_wr_ptr", 0, wp[0], 33);
    cmp("pct_wrapped", 0, wrp[0], 1);
    cmp("pct0_wr_ptr", 1, wp[1], 1);
    cmp("pct0_state", 1, st[1], 3);
    rd_addr = 0;
    cyc(0, 0, 0, 0, 0, 0);
    cmp("pct_rd_pc", 0, rpc[0], 32'h200);
    pc_en = 0;

    // Software trigger with no retire.
    cyc(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 32'h300 + 4 * k, k, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cmp("sw_state", 1, st[1], 3);
    cmp("sw_tidx", 1, tix[1], 3);
    cmp("sw_wr_ptr", 1, wp[1], 3);
    cmp("sw_trig", 1, trg[1], 1);
    cmp("sw_post_state", 0, st[0], 2);

    // Priority: arm beats trigger, stop beats arm.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h400, 1, 0, 0, 0);
    cyc(1, 32'h404, 2, 0, 0, 0);
    cyc(1, 32'h408, 3, 1, 0, 1);
    cmp("prio_state", 0, st[0], 1);
    cmp("prio_wr_ptr", 0, wp[0], 0);
    cyc(0, 0, 0, 1, 1, 0);
    cmp("prio_stop_state", 0, st[0], 0);

    // Asynchronous reset in the middle of post-trigger capture.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h500, 0, 0, 0, 0);
    cyc(1, 32'h504, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 32'h600 + 4 * k, k, 0, 0, 0);
    cmp("pre_rst_state", 0, st[0], 2);
    #2 rst_ni = 1'b0;
    #1;
    cmp("arst_state", 0, st[0], 0);
    cmp("arst_wr_ptr", 0, wp[0], 0);
    cmp("arst_tidx", 0, tix[0], 0);
    cmp("arst_trig", 1, trg[1], 0);
    cmp("arst_rd_pc", 0, rpc[0], 0);
    cmp("arst_rd_instr", 0, rin[0], 0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1, 32'h700 + 4 * k, k, 0, 0, 0);
    cmp("post_rst_wr_ptr", 0, wp[0], 0);
    cmp("post_rst_state", 0, st[0], 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
